// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache; ICACHE_PERF_EN adds perf_hit/perf_miss counters.
// Latency: hit 2 cycles after request, miss 2 + burst + 2; fetch holds ireq, refill advances on cresp.ready.

typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
} msize_t;

typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
} burst_t;

typedef struct packed {
    logic        valid;
    logic [63:0] addr;
} ibus_req_t;

typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
} ibus_resp_t;

typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    burst_t      burst;
} cbus_req_t;

typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
} cbus_resp_t;

module icache_direct #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_BEATS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp,
    input  logic       flush,
    output logic       flush_busy
`ifdef ICACHE_PERF_EN
    ,
    output logic [63:0] perf_hit,
    output logic [63:0] perf_miss
`endif
);

    localparam int OFS_W = $clog2(8 * LINE_BEATS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 64 - OFS_W - IDX_W;
    localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESP
    } state_t;

    state_t state, state_n;

    logic [63:0]          lat_addr;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [63:0]          data_mem [NUM_LINES][LINE_BEATS];
    logic [CNT_W-1:0]     beat_cnt;
    logic                 flush_pend;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] beat_sel;
    logic [63:0]      sel_beat;
    logic [31:0]      sel_word;
    logic             line_hit;
    logic             same_req;
    logic             beat_take;
    logic             flush_req;

    logic clear_all;
    logic take_req;
    logic hit_now;
    logic miss_now;
    logic fill_done;

    // Everything after the request is latched works off lat_addr, so a
    // redirected ireq can never corrupt an in-flight refill.
    assign idx       = lat_addr[OFS_W +: IDX_W];
    assign tag       = lat_addr[63 -: TAG_W];
    assign beat_sel  = (LINE_BEATS > 1) ? lat_addr[3 +: CNT_W] : '0;
    assign sel_beat  = data_mem[idx][beat_sel];
    assign sel_word  = lat_addr[2] ? sel_beat[63:32] : sel_beat[31:0];
    assign line_hit  = valid_q[idx] && (tag_mem[idx] == tag);
    assign same_req  = ireq.valid && (ireq.addr == lat_addr);
    assign beat_take = (state == REFILL) && cresp.ready;
    assign flush_req = flush | flush_pend;
    assign flush_busy = flush_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        clear_all = 1'b0;
        take_req  = 1'b0;
        hit_now   = 1'b0;
        miss_now  = 1'b0;
        fill_done = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    clear_all = 1'b1;
                end else if (ireq.valid) begin
                    take_req = 1'b1;
                    state_n  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!same_req) begin
                    state_n = IDLE;
                end else if (line_hit) begin
                    hit_now = 1'b1;
                    state_n = RESP;
                end else begin
                    miss_now = 1'b1;
                    state_n  = REFILL;
                end
            end
            REFILL: begin
                if (beat_take && cresp.last) begin
                    fill_done = 1'b1;
                    state_n   = LOOKUP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr   <= '0;
            valid_q    <= '0;
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
            iresp      <= '0;
        end else begin
            if (take_req) begin
                lat_addr <= ireq.addr;
            end
            if (clear_all) begin
                valid_q <= '0;
            end else if (fill_done) begin
                valid_q[idx] <= 1'b1;
            end
            // A pulse landing on the clearing cycle is covered by that clear.
            if (clear_all) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
            if (miss_now) begin
                beat_cnt <= '0;
            end else if (beat_take) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            iresp <= '0;
            if (hit_now) begin
                iresp.addr_ok <= 1'b1;
                iresp.data_ok <= 1'b1;
                iresp.data    <= sel_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_take) begin
            data_mem[idx][beat_cnt] <= cresp.data;
        end
        if (fill_done) begin
            tag_mem[idx] <= tag;
        end
    end

    always_comb begin
        creq          = '0;
        creq.valid    = (state == REFILL);
        creq.is_write = 1'b0;
        creq.size     = MSIZE8;
        creq.addr     = {lat_addr[63:OFS_W], {OFS_W{1'b0}}};
        creq.strobe   = '0;
        creq.data     = '0;
        creq.len      = 8'(LINE_BEATS - 1);
        creq.burst    = BURST_INCR;
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit  <= '0;
            perf_miss <= '0;
        end else begin
            if (hit_now) begin
                perf_hit <= perf_hit + 64'd1;
            end
            if (miss_now) begin
                perf_miss <= perf_miss + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: burst memory model plus a line-address reference cache.
module tb_icache_direct;

    localparam int NL         = 16;
    localparam int LB         = 4;
    localparam int LINE_BYTES = 8 * LB;

    logic       clk = 1'b0;
    logic       rst;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    logic       flush;
    logic       flush_busy;
`ifdef ICACHE_PERF_EN
    logic [63:0] perf_hit;
    logic [63:0] perf_miss;
`endif

    int vec   = 0;
    int fails = 0;
    int cyc   = 0;

    bit          mem_active    = 1'b0;
    bit          mem_stall     = 1'b0;
    int          mem_beat      = 0;
    int          mem_wait      = 0;
    int          nrefill       = 0;
    int          last_cyc      = 0;
    logic [63:0] ref_addr      = '0;
    logic [7:0]  ref_len       = '0;
    bit          ref_fmt_ok    = 1'b0;
    bit          creq_unstable = 1'b0;

    bit          mv    [NL];
    logic [63:0] mline [NL];

    icache_direct #(.NUM_LINES(NL), .LINE_BEATS(LB)) dut (
        .clk        (clk),
        .rst        (rst),
        .ireq       (ireq),
        .iresp      (iresp),
        .creq       (creq),
        .cresp      (cresp),
        .flush      (flush),
        .flush_busy (flush_busy)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit   (perf_hit),
        .perf_miss  (perf_miss)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] beat_data(input logic [63:0] b);
        return {b[31:0] ^ 32'hA5A5_0F0F, b[31:0] + 32'h1111_1111};
    endfunction

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic int line_idx(input logic [63:0] a);
        return int'((a / LINE_BYTES) % NL);
    endfunction

    function automatic logic [31:0] exp_word(input logic [63:0] a);
        logic [63:0] bd;
        bd = beat_data(a - (a % 8));
        return a[2] ? bd[63:32] : bd[31:0];
    endfunction

    function automatic bit model_hit(input logic [63:0] a);
        return mv[line_idx(a)] && (mline[line_idx(a)] == line_of(a));
    endfunction

    task automatic model_install(input logic [63:0] a);
        mv[line_idx(a)]    = 1'b1;
        mline[line_idx(a)] = line_of(a);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) mv[i] = 1'b0;
    endtask

    // Memory: first beat one cycle after it sees the request, optional random gaps.
    initial begin
        cresp = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                mem_active = 1'b0;
                cresp      = '0;
            end else if (!mem_active) begin
                cresp = '0;
                if (creq.valid) begin
                    mem_active = 1'b1;
                    mem_beat   = 0;
                    mem_wait   = 0;
                    nrefill++;
                    ref_addr   = creq.addr;
                    ref_len    = creq.len;
                    ref_fmt_ok = !creq.is_write && (creq.size == MSIZE8) &&
                                 (creq.burst == BURST_INCR) && (creq.strobe == 8'd0) &&
                                 (creq.data == 64'd0);
                end
            end else begin
                if (!creq.valid || creq.addr !== ref_addr) creq_unstable = 1'b1;
                if (mem_wait > 0) begin
                    mem_wait--;
                    cresp = '0;
                end else begin
                    cresp.ready = 1'b1;
                    cresp.data  = beat_data(ref_addr + 64'(8 * mem_beat));
                    cresp.last  = (mem_beat == LB - 1);
                    if (cresp.last) begin
                        mem_active = 1'b0;
                        last_cyc   = cyc;
                    end
                    mem_beat++;
                    mem_wait = mem_stall ? int'($urandom_range(0, 2)) : 0;
                end
            end
        end
    end

    task automatic fetch(input logic [63:0] a, input bit stall, input bit with_flush);
        int k, t0, r, exp_r, n0;
        bit exp_miss;
        @(posedge clk); #1;
        mem_stall     = stall;
        creq_unstable = 1'b0;
        ireq.valid    = 1'b1;
        ireq.addr     = a;
        k             = cyc;
        if (with_flush) begin
            flush = 1'b1;
            model_clear();
        end
        t0       = with_flush ? k + 1 : k;
        exp_miss = !model_hit(a);
        n0       = nrefill;
        if (with_flush) begin
            @(posedge clk); #1;
            flush = 1'b0;
        end
        r = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (iresp.data_ok === 1'b1) begin
                r = cyc;
                break;
            end
        end
        vec++;
        if (r < 0) begin
            fails++;
            $display("FAIL fetch_timeout addr=%h: no data_ok within 200 cycles", a);
            ireq.valid = 1'b0;
            return;
        end
        exp_r = exp_miss ? (stall ? last_cyc + 2 : t0 + 4 + LB) : t0 + 2;
        vec++;
        if (r !== exp_r) begin
            fails++;
            $display("FAIL fetch_latency addr=%h miss=%0d: got cycle %0d, expected %0d", a, exp_miss, r, exp_r);
        end
        vec++;
        if (iresp.data !== exp_word(a) || iresp.addr_ok !== 1'b1) begin
            fails++;
            $display("FAIL fetch_data addr=%h: got %h ok=%b, expected %h ok=1", a, iresp.data, iresp.addr_ok, exp_word(a));
        end
        vec++;
        if (nrefill - n0 !== (exp_miss ? 1 : 0)) begin
            fails++;
            $display("FAIL fetch_refills addr=%h: got %0d bursts, expected %0d", a, nrefill - n0, exp_miss ? 1 : 0);
        end
        if (exp_miss) begin
            vec++;
            if (ref_addr !== line_of(a) || ref_len !== 8'(LB - 1) || !ref_fmt_ok || creq_unstable) begin
                fails++;
                $display("FAIL fetch_creq addr=%h: got addr %h len %0d fmt %0d unstable %0d, expected addr %h len %0d",
                         a, ref_addr, ref_len, ref_fmt_ok, creq_unstable, line_of(a), LB - 1);
            end
            model_install(a);
        end
        @(posedge clk); #1;
        ireq.valid = 1'b0;
        @(negedge clk);
        vec++;
        if (iresp.data_ok !== 1'b0) begin
            fails++;
            $display("FAIL fetch_one_cycle addr=%h: data_ok got %b, expected 0", a, iresp.data_ok);
        end
    endtask

    task automatic do_flush();
        int w;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        w = 0;
        while (flush_busy !== 1'b0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        vec++;
        if (flush_busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: flush_busy got %b, expected 0 within 10 cycles", flush_busy);
        end
        model_clear();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        ireq  = '0;
        flush = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        vec++;
        if (iresp !== '0) begin
            fails++;
            $display("FAIL reset_iresp: got %h, expected 0", iresp);
        end
        vec++;
        if (creq.valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_creq_valid: got %b, expected 0", creq.valid);
        end
        vec++;
        if (flush_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_flush_busy: got %b, expected 0", flush_busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cold_miss();
        fetch(64'h8000_0000, 1'b0, 1'b0);
    endtask

    task automatic test_hit();
        fetch(64'h8000_000C, 1'b0, 1'b0);
        fetch(64'h8000_0018, 1'b0, 1'b0);
    endtask

    task automatic test_conflict();
        fetch(64'h8000_0200, 1'b0, 1'b0);
        fetch(64'h8000_0000, 1'b0, 1'b0);
    endtask

    task automatic test_flush_with_req();
        fetch(64'h8000_0004, 1'b0, 1'b1);
        fetch(64'h8000_0200, 1'b0, 1'b0);
    endtask

    task automatic test_redirect();
        logic [63:0] a, b;
        int n0, got, extra;
        a = 64'h8000_0000;
        b = 64'h8000_1000;
        do_flush();
        @(posedge clk); #1;
        mem_stall     = 1'b0;
        creq_unstable = 1'b0;
        n0            = nrefill;
        ireq.valid    = 1'b1;
        ireq.addr     = a;
        for (int i = 0; i < 50 && !(mem_active && mem_beat >= 2); i++) @(negedge clk);
        @(posedge clk); #1;
        ireq.addr = b;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (iresp.data_ok === 1'b1) begin
                got = 1;
                break;
            end
        end
        vec++;
        if (got !== 1 || iresp.data !== exp_word(b)) begin
            fails++;
            $display("FAIL redirect_data: got resp %0d data %h, expected resp 1 data %h", got, iresp.data, exp_word(b));
        end
        @(posedge clk); #1;
        ireq.valid = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (iresp.data_ok === 1'b1) extra++;
        end
        vec++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL redirect_extra_resp: got %0d extra responses, expected 0", extra);
        end
        vec++;
        if (nrefill - n0 !== 2 || ref_addr !== line_of(b) || creq_unstable) begin
            fails++;
            $display("FAIL redirect_refills: got %0d bursts last %h unstable %0d, expected 2 last %h",
                     nrefill - n0, ref_addr, creq_unstable, line_of(b));
        end
        model_install(a);
        model_install(b);
        fetch(b + 64'h4, 1'b0, 1'b0);
        fetch(a, 1'b0, 1'b0);
    endtask

    task automatic test_flush_during_refill();
        fork
            fetch(64'h8000_0400, 1'b0, 1'b0);
            begin
                for (int i = 0; i < 50 && !mem_active; i++) @(negedge clk);
                @(posedge clk); #1;
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    vec++;
                    if (flush_busy !== 1'b1) begin
                        fails++;
                        $display("FAIL flush_busy_refill: got %b, expected 1", flush_busy);
                    end
                end
            end
        join
        vec++;
        if (flush_busy !== 1'b1) begin
            fails++;
            $display("FAIL flush_busy_clear_cycle: got %b, expected 1", flush_busy);
        end
        @(negedge clk);
        vec++;
        if (flush_busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_busy_drop: got %b, expected 0", flush_busy);
        end
        model_clear();
        fetch(64'h8000_0400, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        @(posedge clk); #1;
        mem_stall  = 1'b0;
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0820;
        for (int i = 0; i < 50 && !(mem_active && mem_beat >= 2); i++) @(negedge clk);
        rst = 1'b1;
        #1;
        vec++;
        if (creq.valid !== 1'b0 || iresp !== '0 || flush_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_burst: got creq.valid %b iresp %h busy %b, expected 0 0 0",
                     creq.valid, iresp, flush_busy);
        end
        ireq.valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        fetch(64'h8000_0400, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [63:0] a;
        for (int n = 0; n < 40; n++) begin
            a = 64'h8000_0000 + 64'($urandom_range(0, 2)) * 64'h200
                + 64'($urandom_range(0, 3)) * LINE_BYTES + 64'($urandom_range(0, 7)) * 4;
            fetch(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_with_req();
        test_redirect();
        test_flush_during_refill();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule
